// File: rtl/bsg_cache_pkg.sv
// bsg_cache_pkg: shared types for the cache input pipeline.
//   bsg_cache_opcode_e      6-bit cache opcodes; for loads and stores, opcode[1:0] is the size
//   bsg_cache_decode_s      per-packet decoded control bits
//   bsg_cache_pkt_width()   width of a packed {opcode, addr, data, mask} cache packet
//   bsg_cache_opcode_legal  1 when an opcode is a member of bsg_cache_opcode_e
package bsg_cache_pkg;

  localparam int bsg_cache_opcode_width_gp = 6;

  typedef enum logic [5:0] {
    LB    = 6'h00,
    LH    = 6'h01,
    LW    = 6'h02,
    LD    = 6'h03,
    SB    = 6'h08,
    SH    = 6'h09,
    SW    = 6'h0A,
    SD    = 6'h0B,
    TAGST = 6'h10,
    TAGLA = 6'h11,
    AFL   = 6'h18,
    AINV  = 6'h19
  } bsg_cache_opcode_e;

  // size_op: 0=byte, 1=half, 2=word, 3=double (loads/stores only)
  typedef struct packed {
    logic [1:0] size_op;
    logic       ld_op;
    logic       st_op;
    logic       tagst_op;
    logic       tagla_op;
    logic       afl_op;
    logic       ainv_op;
  } bsg_cache_decode_s;

  // Packet layout, MSB first: {opcode, addr, data, mask}
  function automatic int bsg_cache_pkt_width(input int addr_width, input int data_width);
    return bsg_cache_opcode_width_gp + addr_width + data_width + data_width / 8;
  endfunction

  function automatic logic bsg_cache_opcode_legal(input logic [5:0] opcode);
    case (opcode)
      LB, LH, LW, LD, SB, SH, SW, SD, TAGST, TAGLA, AFL, AINV: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bsg_cache_decode.sv
// bsg_cache_decode: purely combinational opcode decoder.
//   opcode_i   in   6                          packet opcode
//   decode_o   out  $bits(bsg_cache_decode_s)  decoded control bits (all zero when illegal)
//   illegal_o  out  1                          opcode is not a bsg_cache_opcode_e member
module bsg_cache_decode
  import bsg_cache_pkg::*;
(
  input  logic [5:0]                           opcode_i,
  output logic [$bits(bsg_cache_decode_s)-1:0] decode_o,
  output logic                                 illegal_o
);

  bsg_cache_decode_s decode;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    decode = '0;
    case (opcode_i)
      LB, LH, LW, LD: begin
        decode.ld_op   = 1'b1;
        decode.size_op = opcode_i[1:0];
      end
      SB, SH, SW, SD: begin
        decode.st_op   = 1'b1;
        decode.size_op = opcode_i[1:0];
      end
      TAGST:   decode.tagst_op = 1'b1;
      TAGLA:   decode.tagla_op = 1'b1;
      AFL:     decode.afl_op   = 1'b1;
      AINV:    decode.ainv_op  = 1'b1;
      default: ;
    endcase
  end

  assign decode_o  = decode;
  assign illegal_o = ~bsg_cache_opcode_legal(opcode_i);

endmodule

// File: rtl/bsg_cache_decode_stage.sv
// bsg_cache_decode_stage: input stage of the cache pipeline.
// Accepts packets on v_i/ready_o, decodes the opcode once on entry, and holds up to two
// {pkt, decode, illegal} entries in a circular buffer presented in order on v_o/yumi_i.
//   clk_i, reset_i          clock; synchronous active-high reset
//   v_i, cache_pkt_i        upstream packet {opcode, addr, data, mask}
//   ready_o                 registered-only: (count != 2) & ~reset_r
//   v_o, cache_pkt_o        head entry valid / packet
//   decode_o, illegal_o     head decode (computed at enqueue) / illegal flag
//   yumi_i                  downstream consumes head (only while v_o)
//   err_cnt_o               saturating count of dropped illegal packets
// Build option BSG_CACHE_DECODE_STAGE_ILLEGAL_DROP_EN: when defined, illegal packets
// complete the handshake but are not stored, and err_cnt_o counts them; otherwise they
// are stored with illegal_o=1 and err_cnt_o is 0.
module bsg_cache_decode_stage
  import bsg_cache_pkg::*;
#(
  parameter  int addr_width_p    = 32,
  parameter  int data_width_p    = 64,
  localparam int pkt_width_lp    = bsg_cache_pkt_width(addr_width_p, data_width_p),
  localparam int decode_width_lp = $bits(bsg_cache_decode_s)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [pkt_width_lp-1:0]    cache_pkt_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [pkt_width_lp-1:0]    cache_pkt_o,
  output logic [decode_width_lp-1:0] decode_o,
  output logic                       illegal_o,
  input  logic                       yumi_i,
  output logic [7:0]                 err_cnt_o
);

  logic [decode_width_lp-1:0] enq_decode;
  logic                       enq_illegal;

  bsg_cache_decode u_decode (
    .opcode_i  (cache_pkt_i[pkt_width_lp-1 -: bsg_cache_opcode_width_gp]),
    .decode_o  (enq_decode),
    .illegal_o (enq_illegal)
  );

  logic [pkt_width_lp-1:0]    pkt_q     [2];
  logic [pkt_width_lp-1:0]    pkt_d     [2];
  logic [decode_width_lp-1:0] decode_q  [2];
  logic [decode_width_lp-1:0] decode_d  [2];
  logic                       illegal_q [2];
  logic                       illegal_d [2];
  logic                       rptr_q, rptr_d;
  logic                       wptr_q, wptr_d;
  logic [1:0]                 count_q, count_d;
  logic                       reset_r_q, reset_r_d;
  logic                       enq, deq, store;

  // ready_o comes only from flops, so upstream never sees a path from yumi_i.
  assign ready_o = (count_q != 2'd2) && !reset_r_q;
  assign v_o     = (count_q != 2'd0);
  assign enq     = v_i && ready_o;
  assign deq     = yumi_i && v_o;

  assign cache_pkt_o = pkt_q[rptr_q];
  assign decode_o    = decode_q[rptr_q];

`ifdef BSG_CACHE_DECODE_STAGE_ILLEGAL_DROP_EN
  // Illegal packets are consumed upstream but never occupy a slot.
  assign store     = enq && !enq_illegal;
  assign illegal_o = 1'b0;

  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (enq && enq_illegal && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) err_cnt_q <= 8'h00;
    else         err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign store     = enq;
  assign illegal_o = illegal_q[rptr_q];
  assign err_cnt_o = 8'h00;
`endif

  always_comb begin
    reset_r_d = reset_i;
    pkt_d     = pkt_q;
    decode_d  = decode_q;
    illegal_d = illegal_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    if (store) begin
      pkt_d[wptr_q]     = cache_pkt_i;
      decode_d[wptr_q]  = enq_decode;
      illegal_d[wptr_q] = enq_illegal;
      wptr_d            = ~wptr_q;
    end
    if (deq) rptr_d = ~rptr_q;
    // Simultaneous store and deq leave the occupancy unchanged.
    count_d = count_q + 2'(store) - 2'(deq);
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i) begin
    reset_r_q <= reset_r_d;
    if (reset_i) begin
      count_q <= 2'd0;
      rptr_q  <= 1'b0;
      wptr_q  <= 1'b0;
      // NOTE: the storage entries are reset too, because the head outputs are defined
      // as zero after reset and are driven straight from the entry at rptr.
      for (int i = 0; i < 2; i++) begin
        pkt_q[i]     <= '0;
        decode_q[i]  <= '0;
        illegal_q[i] <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      for (int i = 0; i < 2; i++) begin
        pkt_q[i]     <= pkt_d[i];
        decode_q[i]  <= decode_d[i];
        illegal_q[i] <= illegal_d[i];
      end
    end
  end

`ifndef SYNTHESIS
  a_yumi_needs_valid : assert property (@(posedge clk_i) disable iff (reset_i)
    !(yumi_i && !v_o))
    else $error("yumi_i asserted while v_o is low");

  a_upstream_hold : assert property (@(posedge clk_i) disable iff (reset_i)
    (v_i && !ready_o) |=> (v_i && $stable(cache_pkt_i)))
    else $error("upstream dropped or changed a packet while ready_o was low");
`endif

endmodule
